// File: rtl/mem_stack_pkg.sv
// Shared constants for the MEM side-bus stack peripherals: slot indices,
// stack operation encodings and the operation decoder.
package mem_stack_pkg;

    // MEM slot indices
    localparam int MEM_STATUS    = 0;
    localparam int MEM_ADDRSTACK = 1;
    localparam int MEM_USERSTACK = 2;
    localparam int MEM_UART      = 3;
    localparam int MEM_GPIO      = 4;
    localparam int MEM_GPIODIR   = 5;

    // Default stack geometry
    localparam int STACK_DEPTH = 64;
    localparam int STACK_WIDTH = 16;

    // Stack operation encodings
    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_REPL = 2'd3
    } stackOp_e;

    // Write alone pushes, read alone pops, both together replace the top.
    function automatic stackOp_e decodeOp(input logic write, input logic read);
        case ({write, read})
            2'b10:   return OP_PUSH;
            2'b01:   return OP_POP;
            2'b11:   return OP_REPL;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_stack_if.sv
// Bus bundle between the MEM decode/read-mux side (master) and a stack
// peripheral (slave).
interface mem_stack_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 6
) ();
    logic             sel;
    logic             write;
    logic             read;
    logic             clr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [AW:0]      count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output sel, write, read, clr, din,
        input  dout, count, empty, full, overflow, underflow
    );

    modport slave (
        input  sel, write, read, clr, din,
        output dout, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/mem_stack_mem.sv
// Stack storage below the top entry: DEPTH x WIDTH, synchronous write port,
// asynchronous read port (maps to distributed RAM). Contents are not reset.
module stack_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             CLK,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: one entry per cycle when enabled
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/mem_stack.sv
// Memory-mapped LIFO on the MEM side-bus. Bus writes push, read strobes pop,
// both together replace the top. The top entry lives in a register so dout is
// registered; deeper entries live in stack_mem at [0..count-2].
module mem_stack
    import mem_stack_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input logic         CLK,
    input logic         RST,
    mem_stack_if.slave  bus
);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] topQ;
    logic [AW:0]      countQ;
    logic             ovfQ;
    logic             unfQ;

    stackOp_e         op;
    logic             isEmpty;
    logic             isFull;
    logic             memWe;
    logic [AW-1:0]    memWaddr;
    logic [AW-1:0]    memRaddr;
    logic [WIDTH-1:0] memRdata;

    assign op      = decodeOp(bus.write, bus.read);
    assign isEmpty = (countQ == '0);
    assign isFull  = (countQ == CNT_FULL);

    // Only a real push onto a non-empty stack spills the old top into the
    // array; a replace or a push onto an empty stack touches topQ alone.
    // Low AW bits wrap correctly for count==DEPTH (index DEPTH-1).
    assign memWe    = bus.sel && !bus.clr && (op == OP_PUSH) && !isFull && !isEmpty;
    assign memWaddr = countQ[AW-1:0] - AW'(1);
    assign memRaddr = countQ[AW-1:0] - AW'(2);

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) uMem (
        .CLK   (CLK),
        .we    (memWe),
        .waddr (memWaddr),
        .wdata (topQ),
        .raddr (memRaddr),
        .rdata (memRdata)
    );

    // Top-of-stack, occupancy and sticky flags; clr beats any push/pop
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            topQ   <= '0;
            countQ <= '0;
            ovfQ   <= 1'b0;
            unfQ   <= 1'b0;
        end else if (bus.sel) begin
            if (bus.clr) begin
                topQ   <= '0;
                countQ <= '0;
                ovfQ   <= 1'b0;
                unfQ   <= 1'b0;
            end else begin
                case (op)
                    OP_PUSH: begin
                        if (isFull) begin
                            ovfQ <= 1'b1;
                        end else begin
                            topQ   <= bus.din;
                            countQ <= countQ + CNT_ONE;
                        end
                    end
                    OP_REPL: begin
                        // On an empty stack a replace degenerates to a push
                        topQ <= bus.din;
                        if (isEmpty) begin
                            countQ <= CNT_ONE;
                        end
                    end
                    OP_POP: begin
                        if (isEmpty) begin
                            unfQ <= 1'b1;
                        end else if (countQ == CNT_ONE) begin
                            topQ   <= '0;
                            countQ <= '0;
                        end else begin
                            topQ   <= memRdata;
                            countQ <= countQ - CNT_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.dout      = topQ;
    assign bus.count     = countQ;
    assign bus.empty     = isEmpty;
    assign bus.full      = isFull;
    assign bus.overflow  = ovfQ;
    assign bus.underflow = unfQ;
endmodule

// File: tb/tb_mem_stack.sv
// Self-checking bench for mem_stack: directed scenarios plus a randomized run,
// all checked against a queue-based LIFO model.
module tb_mem_stack;
    localparam int WIDTH = 16;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    mem_stack_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    mem_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    int cmpCount = 0;
    int errCount = 0;

    // Reference model: a plain queue, back = top of stack
    logic [WIDTH-1:0] stk[$];
    bit ovf = 0;
    bit unf = 0;

    task automatic modelStep(input bit s, input bit w, input bit r, input bit c,
                             input logic [WIDTH-1:0] d);
        if (!s) return;
        if (c) begin
            stk.delete();
            ovf = 0;
            unf = 0;
        end else if (w && (!r || stk.size() == 0)) begin
            if (stk.size() == DEPTH) ovf = 1;
            else stk.push_back(d);
        end else if (w && r) begin
            stk[stk.size()-1] = d;
        end else if (r) begin
            if (stk.size() == 0) unf = 1;
            else void'(stk.pop_back());
        end
    endtask

    function automatic logic [WIDTH+AW+4:0] expState();
        logic [WIDTH-1:0] top;
        int n;
        n = stk.size();
        top = (n > 0) ? stk[n-1] : '0;
        return {top, (AW+1)'(n), n == 0, n == DEPTH, ovf, unf};
    endfunction

    function automatic logic [WIDTH+AW+4:0] dutState();
        return {bus.dout, bus.count, bus.empty, bus.full, bus.overflow, bus.underflow};
    endfunction

    task automatic idleInputs();
        bus.sel = 0; bus.write = 0; bus.read = 0; bus.clr = 0; bus.din = '0;
    endtask

    // Apply one cycle of bus activity; returns #1 after the sampling edge
    task automatic stepOp(input bit s, input bit w, input bit r, input bit c,
                          input logic [WIDTH-1:0] d);
        bus.sel = s; bus.write = w; bus.read = r; bus.clr = c; bus.din = d;
        @(posedge CLK);
        modelStep(s, w, r, c, d);
        #1;
        idleInputs();
    endtask

    task automatic test_reset();
        stepOp(1, 1, 0, 0, 16'h1234);
        stepOp(1, 1, 0, 0, 16'h5678);
        stepOp(1, 0, 1, 0, 16'h0);
        stepOp(1, 0, 1, 0, 16'h0);
        stepOp(1, 0, 1, 0, 16'h0);  // underflow set
        bus.sel = 1; bus.write = 1; bus.din = 16'hBEEF;
        #2;
        RST = 1;
        #1;
        stk.delete(); ovf = 0; unf = 0;
        cmpCount++;
        if (dutState() !== {16'h0, 7'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errCount++;
            $display("FAIL reset_async: got %h expected %h", dutState(), {16'h0, 7'd0, 4'b1000});
        end
        @(posedge CLK); #1;
        cmpCount++;
        if (dutState() !== expState()) begin
            errCount++;
            $display("FAIL reset_held: got %h expected %h", dutState(), expState());
        end
        RST = 0;
        idleInputs();
    endtask

    task automatic test_push_pop();
        logic [WIDTH-1:0] vals [3] = '{16'h1111, 16'h2222, 16'h3333};
        logic [WIDTH-1:0] after [3] = '{16'h2222, 16'h1111, 16'h0000};
        for (int i = 0; i < 3; i++) stepOp(1, 1, 0, 0, vals[i]);
        cmpCount++;
        if (bus.dout !== 16'h3333 || bus.count !== 7'd3 || dutState() !== expState()) begin
            errCount++;
            $display("FAIL push3: got %h expected %h", dutState(), expState());
        end
        for (int i = 0; i < 3; i++) begin
            stepOp(1, 0, 1, 0, 16'h0);
            cmpCount++;
            if (bus.dout !== after[i] || dutState() !== expState()) begin
                errCount++;
                $display("FAIL pop%0d: dout %h expected %h state %h", i, bus.dout, after[i], expState());
            end
        end
        cmpCount++;
        if (bus.empty !== 1'b1 || bus.count !== 7'd0) begin
            errCount++;
            $display("FAIL pop_empty: empty %b count %0d expected 1/0", bus.empty, bus.count);
        end
    endtask

    task automatic test_underflow();
        stepOp(1, 0, 1, 0, 16'h0);
        cmpCount++;
        if (bus.underflow !== 1'b1 || bus.count !== 7'd0 || bus.dout !== 16'h0) begin
            errCount++;
            $display("FAIL underflow: got %h expected %h", dutState(), expState());
        end
        stepOp(1, 1, 0, 0, 16'h00AA);
        cmpCount++;
        if (bus.underflow !== 1'b1 || dutState() !== expState()) begin
            errCount++;
            $display("FAIL underflow_sticky: got %h expected %h", dutState(), expState());
        end
        stepOp(1, 0, 0, 1, 16'h0);
        cmpCount++;
        if (bus.underflow !== 1'b0 || bus.count !== 7'd0 || dutState() !== expState()) begin
            errCount++;
            $display("FAIL underflow_clr: got %h expected %h", dutState(), expState());
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) stepOp(1, 1, 0, 0, 16'(i));
        cmpCount++;
        if (bus.full !== 1'b1 || bus.overflow !== 1'b0 || bus.count !== 7'd64) begin
            errCount++;
            $display("FAIL fill: got %h expected %h", dutState(), expState());
        end
        stepOp(1, 1, 0, 0, 16'hFFFF);
        cmpCount++;
        if (bus.full !== 1'b1 || bus.overflow !== 1'b1 || bus.dout !== 16'h003F ||
            dutState() !== expState()) begin
            errCount++;
            $display("FAIL overflow: got %h expected %h", dutState(), expState());
        end
        for (int i = 0; i < DEPTH; i++) begin
            cmpCount++;
            if (bus.dout !== 16'(DEPTH-1-i)) begin
                errCount++;
                $display("FAIL drain_%0d: dout %h expected %h", i, bus.dout, 16'(DEPTH-1-i));
            end
            stepOp(1, 0, 1, 0, 16'h0);
        end
        cmpCount++;
        if (dutState() !== expState() || bus.empty !== 1'b1) begin
            errCount++;
            $display("FAIL drained: got %h expected %h", dutState(), expState());
        end
        stepOp(1, 0, 0, 1, 16'h0);
    endtask

    task automatic test_replace();
        stepOp(1, 1, 0, 0, 16'h000A);
        stepOp(1, 1, 0, 0, 16'h000B);
        stepOp(1, 1, 1, 0, 16'h000C);
        cmpCount++;
        if (bus.dout !== 16'h000C || bus.count !== 7'd2 || dutState() !== expState()) begin
            errCount++;
            $display("FAIL replace: got %h expected %h", dutState(), expState());
        end
        stepOp(1, 0, 1, 0, 16'h0);
        cmpCount++;
        if (bus.dout !== 16'h000A || bus.count !== 7'd1) begin
            errCount++;
            $display("FAIL replace_pop: dout %h count %0d expected 000a/1", bus.dout, bus.count);
        end
        stepOp(1, 0, 1, 0, 16'h0);
        stepOp(1, 1, 1, 0, 16'h0077);  // replace on empty acts as push
        cmpCount++;
        if (bus.dout !== 16'h0077 || bus.count !== 7'd1 || dutState() !== expState()) begin
            errCount++;
            $display("FAIL replace_empty: got %h expected %h", dutState(), expState());
        end
        stepOp(1, 0, 0, 1, 16'h0);
    endtask

    task automatic test_sel_clr();
        stepOp(1, 1, 0, 0, 16'h0042);
        stepOp(0, 1, 0, 0, 16'h0099);
        stepOp(0, 0, 1, 0, 16'h0);
        cmpCount++;
        if (bus.dout !== 16'h0042 || bus.count !== 7'd1 || dutState() !== expState()) begin
            errCount++;
            $display("FAIL sel_low: got %h expected %h", dutState(), expState());
        end
        stepOp(1, 0, 1, 0, 16'h0);
        stepOp(1, 0, 1, 0, 16'h0);  // underflow
        stepOp(1, 1, 0, 0, 16'h0055);
        stepOp(1, 1, 0, 1, 16'h0066);
        cmpCount++;
        if (bus.count !== 7'd0 || bus.dout !== 16'h0 || bus.underflow !== 1'b0 ||
            dutState() !== expState()) begin
            errCount++;
            $display("FAIL clr_push: got %h expected %h", dutState(), expState());
        end
        stepOp(1, 1, 0, 0, 16'h0011);
        stepOp(1, 0, 1, 1, 16'h0);
        cmpCount++;
        if (bus.count !== 7'd0 || dutState() !== expState()) begin
            errCount++;
            $display("FAIL clr_pop: got %h expected %h", dutState(), expState());
        end
    endtask

    task automatic test_back_to_back();
        int r;
        bit s, w, rd, c;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            r  = $urandom_range(0, 99);
            s  = (r < 92);
            // Bias toward pushes in the first phase so full/overflow gets exercised
            r  = $urandom_range(0, 99);
            c  = (r < 2);
            if (cyc < 700) begin
                w  = (r >= 2 && r < 75) || (r >= 90);
                rd = (r >= 75);
            end else begin
                w  = (r >= 2 && r < 45) || (r >= 90);
                rd = (r >= 45);
            end
            stepOp(s, w, rd, c, 16'($urandom));
            cmpCount++;
            if (dutState() !== expState()) begin
                errCount++;
                $display("FAIL random_%0d: got %h expected %h", cyc, dutState(), expState());
            end
        end
    endtask

    initial begin
        idleInputs();
        repeat (2) @(posedge CLK);
        #1;
        RST = 0;
        cmpCount++;
        if (dutState() !== expState()) begin
            errCount++;
            $display("FAIL initial_reset: got %h expected %h", dutState(), expState());
        end
        test_reset();
        test_push_pop();
        test_underflow();
        test_fill();
        test_replace();
        test_sel_clr();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end
endmodule
